// File: rtl/rf_write_driver_pkg.sv
// Shared types and default widths for the register-file write driver.
// The default widths follow the REG_FILE depth and word constants used in test_util.
package rf_write_driver_pkg;

  localparam int unsigned RWD_ADDR_W = 6;
  localparam int unsigned RWD_DATA_W = 16;
  localparam int unsigned RWD_CNT_W  = 7;
  localparam int unsigned RWD_DLY_W  = 6;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_WRITE  = 2'd2,
    S_FINISH = 2'd3
  } rwd_state_t;

  typedef struct packed {
    logic [RWD_ADDR_W-1:0] start;
    logic [RWD_ADDR_W-1:0] stride;
    logic [RWD_CNT_W-1:0]  count;
    logic [RWD_DLY_W-1:0]  delay;
  } rwd_cmd_t;

endpackage

// File: rtl/rwd_addr_gen.sv
// AGU-style linear address generator with a remaining-beat counter.
// The address wraps modulo 2**ADDR_W in both directions.
module rwd_addr_gen #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned CNT_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] start,
  input  logic [ADDR_W-1:0] stride,
  input  logic [CNT_W-1:0]  count,
  input  logic              step,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              last
);

  logic [ADDR_W-1:0] stride_q;
  logic [CNT_W-1:0]  remaining;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr  <= '0;
      stride_q  <= '0;
      remaining <= '0;
    end else if (load) begin
      cur_addr  <= start;
      stride_q  <= stride;
      remaining <= count;
    end else if (step) begin
      // a negative stride is its two's complement, so plain addition wraps correctly
      cur_addr  <= cur_addr + stride_q;
      remaining <= remaining - 1'b1;
    end
  end

  assign last = (remaining == CNT_W'(1));

endmodule

// File: rtl/rf_write_driver.sv
// Drives one register-file write port with a linear burst pattern.
// Burst commands and write data both arrive over valid/ready.
module rf_write_driver
  import rf_write_driver_pkg::*;
#(
  parameter int unsigned ADDR_W = RWD_ADDR_W,
  parameter int unsigned DATA_W = RWD_DATA_W,
  parameter int unsigned CNT_W  = RWD_CNT_W,
  parameter int unsigned DLY_W  = RWD_DLY_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_start,
  input  logic [ADDR_W-1:0] cmd_stride,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic [DLY_W-1:0]  cmd_delay,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [DATA_W-1:0] din_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [15:0]       wr_total
);

  rwd_state_t        state, next_state;
  logic [DLY_W-1:0]  dly_cnt;
  logic [ADDR_W-1:0] cur_addr;
  logic              last;
  logic              cmd_fire;
  logic              accept;

  assign cmd_ready = (state == S_IDLE);
  assign din_ready = (state == S_WRITE);
  assign busy      = (state != S_IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign accept    = din_valid && din_ready;

  rwd_addr_gen #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (cmd_fire),
    .start    (cmd_start),
    .stride   (cmd_stride),
    .count    (cmd_count),
    .step     (accept),
    .cur_addr (cur_addr),
    .last     (last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (cmd_fire) begin
          if (cmd_count == '0)      next_state = S_FINISH;
          else if (cmd_delay == '0) next_state = S_WRITE;
          else                      next_state = S_DELAY;
        end
      end
      S_DELAY:  if (dly_cnt == DLY_W'(1)) next_state = S_WRITE;
      S_WRITE:  if (accept && last)       next_state = S_IDLE;
      S_FINISH: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // outputs are registered so done lines up with the final wr_en of the burst
  always_ff @(posedge clk) begin
    if (rst) begin
      dly_cnt  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
      wr_total <= '0;
    end else begin
      if (cmd_fire)               dly_cnt <= cmd_delay;
      else if (state == S_DELAY)  dly_cnt <= dly_cnt - 1'b1;
      wr_en <= accept;
      done  <= (state == S_FINISH) || (accept && last);
      if (accept) begin
        wr_addr <= cur_addr;
        wr_data <= din_data;
        if (wr_total != 16'hFFFF) wr_total <= wr_total + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_driver.sv
// Directed self-checking bench for rf_write_driver.
module tb_rf_write_driver;
  import rf_write_driver_pkg::*;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_start;
  logic [5:0]  cmd_stride;
  logic [6:0]  cmd_count;
  logic [5:0]  cmd_delay;
  logic        din_valid;
  logic        din_ready;
  logic [15:0] din_data;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;
  logic [15:0] wr_total;

  int n_checks = 0;
  int n_fail   = 0;

  rf_write_driver #(
    .ADDR_W (6),
    .DATA_W (16),
    .CNT_W  (7),
    .DLY_W  (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_start  (cmd_start),
    .cmd_stride (cmd_stride),
    .cmd_count  (cmd_count),
    .cmd_delay  (cmd_delay),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din_data   (din_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .wr_total   (wr_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input rwd_cmd_t c);
    cmd_start  = c.start;
    cmd_stride = c.stride;
    cmd_count  = c.count;
    cmd_delay  = c.delay;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %0b expected 0", wr_en); end
    n_checks++; if (wr_addr !== 6'd0) begin n_fail++; $display("FAIL reset_wr_addr: got %0d expected 0", wr_addr); end
    n_checks++; if (wr_data !== 16'd0) begin n_fail++; $display("FAIL reset_wr_data: got %h expected 0000", wr_data); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done); end
    n_checks++; if (wr_total !== 16'd0) begin n_fail++; $display("FAIL reset_wr_total: got %0d expected 0", wr_total); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %0b expected 1", cmd_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL reset_din_ready: got %0b expected 0", din_ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [5:0]  ea;
    logic [15:0] ed;
    set_cmd('{start: 6'd4, stride: 6'd1, count: 7'd4, delay: 6'd0});
    cmd_valid = 1'b1;
    din_valid = 1'b1;
    din_data  = 16'h00A0;
    tick();
    cmd_valid = 1'b0;
    n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL basic_din_ready: got %0b expected 1", din_ready); end
    for (int i = 0; i < 4; i++) begin
      din_data = 16'h00A0 + 16'(i);
      tick();
      ea = 6'd4 + 6'(i);
      ed = 16'h00A0 + 16'(i);
      n_checks++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL basic_wr_en[%0d]: got %0b expected 1", i, wr_en); end
      n_checks++; if (wr_addr !== ea) begin n_fail++; $display("FAIL basic_wr_addr[%0d]: got %0d expected %0d", i, wr_addr, ea); end
      n_checks++; if (wr_data !== ed) begin n_fail++; $display("FAIL basic_wr_data[%0d]: got %h expected %h", i, wr_data, ed); end
      n_checks++; if (done !== (i == 3)) begin n_fail++; $display("FAIL basic_done[%0d]: got %0b expected %0b", i, done, (i == 3)); end
    end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL basic_cmd_ready_at_done: got %0b expected 1", cmd_ready); end
    din_valid = 1'b0;
    tick();
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL basic_wr_en_after: got %0b expected 0", wr_en); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_after: got %0b expected 0", done); end
    n_checks++; if (wr_total !== 16'd4) begin n_fail++; $display("FAIL basic_wr_total: got %0d expected 4", wr_total); end
  endtask

  task automatic test_wrap();
    logic [5:0] exp_addr [3] = '{6'd1, 6'd63, 6'd61};
    set_cmd('{start: 6'd1, stride: 6'h3E, count: 7'd3, delay: 6'd0});
    cmd_valid = 1'b1;
    din_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    // command fields change after the handshake and must be ignored
    set_cmd('{start: 6'd9, stride: 6'd7, count: 7'd50, delay: 6'd5});
    for (int i = 0; i < 3; i++) begin
      din_data = 16'h0B00 + 16'(i);
      tick();
      n_checks++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL wrap_wr_en[%0d]: got %0b expected 1", i, wr_en); end
      n_checks++; if (wr_addr !== exp_addr[i]) begin n_fail++; $display("FAIL wrap_wr_addr[%0d]: got %0d expected %0d", i, wr_addr, exp_addr[i]); end
      n_checks++; if (done !== (i == 2)) begin n_fail++; $display("FAIL wrap_done[%0d]: got %0b expected %0b", i, done, (i == 2)); end
    end
    din_valid = 1'b0;
    tick();
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL wrap_wr_en_after: got %0b expected 0", wr_en); end
    n_checks++; if (wr_total !== 16'd7) begin n_fail++; $display("FAIL wrap_wr_total: got %0d expected 7", wr_total); end
  endtask

  task automatic test_delay_stall();
    set_cmd('{start: 6'd20, stride: 6'd5, count: 7'd2, delay: 6'd3});
    cmd_valid = 1'b1;
    din_valid = 1'b0;
    tick();
    cmd_valid = 1'b0;
    // three cycles in DELAY, then WRITE
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (din_ready !== (k == 3)) begin n_fail++; $display("FAIL delay_din_ready[%0d]: got %0b expected %0b", k, din_ready, (k == 3)); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL delay_busy[%0d]: got %0b expected 1", k, busy); end
      if (k < 3) tick();
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL stall_wr_en[%0d]: got %0b expected 0", k, wr_en); end
      n_checks++; if (wr_addr !== 6'd61) begin n_fail++; $display("FAIL stall_wr_addr_hold[%0d]: got %0d expected 61", k, wr_addr); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL stall_done[%0d]: got %0b expected 0", k, done); end
    end
    din_valid = 1'b1;
    din_data  = 16'hBEEF;
    tick();
    n_checks++; if (wr_en !== 1'b1 || wr_addr !== 6'd20 || wr_data !== 16'hBEEF || done !== 1'b0) begin
      n_fail++; $display("FAIL stall_beat0: got en=%0b addr=%0d data=%h done=%0b expected en=1 addr=20 data=beef done=0", wr_en, wr_addr, wr_data, done);
    end
    din_data = 16'hCAFE;
    tick();
    n_checks++; if (wr_en !== 1'b1 || wr_addr !== 6'd25 || wr_data !== 16'hCAFE || done !== 1'b1) begin
      n_fail++; $display("FAIL stall_beat1: got en=%0b addr=%0d data=%h done=%0b expected en=1 addr=25 data=cafe done=1", wr_en, wr_addr, wr_data, done);
    end
    din_valid = 1'b0;
    tick();
    n_checks++; if (done !== 1'b0 || wr_en !== 1'b0) begin n_fail++; $display("FAIL stall_after: got en=%0b done=%0b expected en=0 done=0", wr_en, done); end
    n_checks++; if (wr_total !== 16'd9) begin n_fail++; $display("FAIL stall_wr_total: got %0d expected 9", wr_total); end
  endtask

  task automatic test_zero_count();
    set_cmd('{start: 6'd33, stride: 6'd1, count: 7'd0, delay: 6'd0});
    cmd_valid = 1'b1;
    din_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n_checks++; if (busy !== 1'b1 || done !== 1'b0 || wr_en !== 1'b0) begin
      n_fail++; $display("FAIL zero_cycle1: got busy=%0b done=%0b en=%0b expected busy=1 done=0 en=0", busy, done, wr_en);
    end
    tick();
    n_checks++; if (busy !== 1'b0 || done !== 1'b1 || wr_en !== 1'b0) begin
      n_fail++; $display("FAIL zero_cycle2: got busy=%0b done=%0b en=%0b expected busy=0 done=1 en=0", busy, done, wr_en);
    end
    din_valid = 1'b0;
    tick();
    n_checks++; if (done !== 1'b0 || wr_en !== 1'b0) begin n_fail++; $display("FAIL zero_cycle3: got done=%0b en=%0b expected 0 0", done, wr_en); end
    n_checks++; if (wr_total !== 16'd9) begin n_fail++; $display("FAIL zero_wr_total: got %0d expected 9", wr_total); end
  endtask

  task automatic test_reset_mid_burst();
    set_cmd('{start: 6'd30, stride: 6'd1, count: 7'd8, delay: 6'd0});
    cmd_valid = 1'b1;
    din_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din_data = 16'h0C00 + 16'(i);
      tick();
      n_checks++; if (wr_en !== 1'b1 || wr_addr !== 6'd30 + 6'(i)) begin
        n_fail++; $display("FAIL rstmid_beat[%0d]: got en=%0b addr=%0d expected en=1 addr=%0d", i, wr_en, wr_addr, 30 + i);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    din_valid = 1'b0;
    n_checks++; if (wr_en !== 1'b0 || wr_addr !== 6'd0 || wr_data !== 16'd0 || done !== 1'b0 || wr_total !== 16'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_outputs: got en=%0b addr=%0d data=%h done=%0b total=%0d busy=%0b expected all 0", wr_en, wr_addr, wr_data, done, wr_total, busy);
    end
    tick();
    n_checks++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_idle: got done=%0b cmd_ready=%0b expected 0 1", done, cmd_ready); end
    set_cmd('{start: 6'd10, stride: 6'd1, count: 7'd1, delay: 6'd0});
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    din_valid = 1'b1;
    din_data  = 16'h1234;
    tick();
    din_valid = 1'b0;
    n_checks++; if (wr_en !== 1'b1 || wr_addr !== 6'd10 || wr_data !== 16'h1234 || done !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_new_cmd: got en=%0b addr=%0d data=%h done=%0b expected en=1 addr=10 data=1234 done=1", wr_en, wr_addr, wr_data, done);
    end
    n_checks++; if (wr_total !== 16'd1) begin n_fail++; $display("FAIL rstmid_wr_total: got %0d expected 1", wr_total); end
    tick();
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_after: got en=%0b expected 0", wr_en); end
  endtask

  task automatic test_back_to_back();
    logic        exp_en   [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [5:0]  exp_addr [5] = '{6'd40, 6'd42, 6'd42, 6'd40, 6'd42};
    logic [15:0] exp_data [5] = '{16'hD000, 16'hD001, 16'hD001, 16'hD002, 16'hD003};
    logic        exp_done [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        exp_busy [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int beat = 0;
    logic was_ready;
    set_cmd('{start: 6'd40, stride: 6'd2, count: 7'd2, delay: 6'd0});
    cmd_valid = 1'b1;
    din_valid = 1'b1;
    din_data  = 16'hD000;
    tick();
    for (int cyc = 1; cyc <= 6; cyc++) begin
      if (cyc >= 2) begin
        n_checks++; if (wr_en !== exp_en[cyc-2] || wr_addr !== exp_addr[cyc-2] || wr_data !== exp_data[cyc-2] ||
                        done !== exp_done[cyc-2] || busy !== exp_busy[cyc-2]) begin
          n_fail++; $display("FAIL b2b_cycle%0d: got en=%0b addr=%0d data=%h done=%0b busy=%0b expected en=%0b addr=%0d data=%h done=%0b busy=%0b",
                             cyc, wr_en, wr_addr, wr_data, done, busy, exp_en[cyc-2], exp_addr[cyc-2], exp_data[cyc-2], exp_done[cyc-2], exp_busy[cyc-2]);
        end
      end
      if (cyc == 6) begin
        cmd_valid = 1'b0;
        din_valid = 1'b0;
      end
      din_data  = 16'hD000 + 16'(beat);
      was_ready = din_ready && din_valid;
      tick();
      if (was_ready) beat++;
    end
    n_checks++; if (wr_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_after: got en=%0b done=%0b busy=%0b expected 0 0 0", wr_en, done, busy);
    end
    n_checks++; if (wr_total !== 16'd5) begin n_fail++; $display("FAIL b2b_wr_total: got %0d expected 5", wr_total); end
  endtask

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_start  = '0;
    cmd_stride = '0;
    cmd_count  = '0;
    cmd_delay  = '0;
    din_valid  = 1'b0;
    din_data   = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_delay_stall();
    test_zero_count();
    test_reset_mid_burst();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
